// File: rtl/quad_serializer.sv
// Buffers 4-pixel RGB quads from the shader and serializes them one pixel per
// transfer toward scanout, tracking raster position for SOF/EOL markers.
module quad_serializer #(
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              R_quad,
  input  logic [31:0]              G_quad,
  input  logic [31:0]              B_quad,
  input  logic                     valid_in,
  input  logic                     sync_clear,
  input  logic                     pix_ready,
  output logic [7:0]               pix_r,
  output logic [7:0]               pix_g,
  output logic [7:0]               pix_b,
  output logic                     pix_valid,
  output logic                     pix_sof,
  output logic                     pix_eol,
  output logic                     almost_full,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int unsigned YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;

  logic [95:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [1:0]    lane_q, lane_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          ovf_q, ovf_d;

  logic          full, push, xfer, pop;
  logic [95:0]   head;

  always_comb begin
    full      = (count_q == (AW+1)'(DEPTH));
    push      = valid_in && !full && !sync_clear;
    pix_valid = (count_q != '0);
    xfer      = pix_valid && pix_ready;
    pop       = xfer && (lane_q == 2'd3);

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    lane_d   = lane_q;
    x_d      = x_q;
    y_d      = y_q;
    ovf_d    = ovf_q;

    if (sync_clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      lane_d   = '0;
      x_d      = '0;
      y_d      = '0;
      ovf_d    = 1'b0;
    end else begin
      // Fullness uses the pre-edge count, so a same-cycle pop cannot rescue a push.
      if (valid_in && full) ovf_d = 1'b1;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
      if (xfer) begin
        lane_d = lane_q + 2'd1;
        if (x_q == XW'(H_ACTIVE - 1)) begin
          x_d = '0;
          y_d = (y_q == YW'(V_ACTIVE - 1)) ? '0 : y_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      lane_q   <= '0;
      x_q      <= '0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      lane_q   <= lane_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {R_quad, G_quad, B_quad};
  end

  always_comb begin
    head  = mem_q[rd_ptr_q];
    pix_r = '0;
    pix_g = '0;
    pix_b = '0;
    // Gate with pix_valid so the unreset storage never leaks out while empty.
    if (pix_valid) begin
      case (lane_q)
        2'd0: begin pix_r = head[95:88]; pix_g = head[63:56]; pix_b = head[31:24]; end
        2'd1: begin pix_r = head[87:80]; pix_g = head[55:48]; pix_b = head[23:16]; end
        2'd2: begin pix_r = head[79:72]; pix_g = head[47:40]; pix_b = head[15:8];  end
        default: begin pix_r = head[71:64]; pix_g = head[39:32]; pix_b = head[7:0]; end
      endcase
    end
    pix_sof     = pix_valid && (x_q == '0) && (y_q == '0);
    pix_eol     = pix_valid && (x_q == XW'(H_ACTIVE - 1));
    almost_full = (count_q >= (AW+1)'(DEPTH - 1));
    overflow    = ovf_q;
    fifo_count  = count_q;
  end

endmodule

// File: tb/tb_quad_serializer.sv
// Directed bench for quad_serializer with a small raster (8x2) and a 4-deep FIFO.
module tb_quad_serializer;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] R_quad, G_quad, B_quad;
  logic        valid_in, sync_clear, pix_ready;
  logic [7:0]  pix_r, pix_g, pix_b;
  logic        pix_valid, pix_sof, pix_eol, almost_full, overflow;
  logic [2:0]  fifo_count;

  int unsigned tests = 0;
  int unsigned fails = 0;

  quad_serializer #(.DEPTH(4), .H_ACTIVE(8), .V_ACTIVE(2)) dut (
    .clk(clk), .rst(rst),
    .R_quad(R_quad), .G_quad(G_quad), .B_quad(B_quad),
    .valid_in(valid_in), .sync_clear(sync_clear), .pix_ready(pix_ready),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_eol(pix_eol),
    .almost_full(almost_full), .overflow(overflow), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] qr(input int unsigned i);
    logic [7:0] b;
    b = 8'(8'h40 + 8'(16 * i));
    return {b, b + 8'd1, b + 8'd2, b + 8'd3};
  endfunction
  function automatic logic [31:0] qg(input int unsigned i);
    return ~qr(i);
  endfunction
  function automatic logic [31:0] qb(input int unsigned i);
    return qr(i) ^ 32'h5A5A5A5A;
  endfunction
  function automatic logic [7:0] lb(input logic [31:0] w, input int unsigned l);
    return w[31 - 8*l -: 8];
  endfunction

  task automatic set_quad(input int unsigned i);
    R_quad = qr(i);
    G_quad = qg(i);
    B_quad = qb(i);
  endtask

  initial begin
    logic [63:0] seq;
    rst = 1'b1; valid_in = 1'b0; sync_clear = 1'b0; pix_ready = 1'b0;
    R_quad = '0; G_quad = '0; B_quad = '0;
    #2;
    chk("rst_count", 32'(fifo_count), 32'd0);
    chk("rst_valid", 32'(pix_valid), 32'd0);
    chk("rst_sof", 32'(pix_sof), 32'd0);
    chk("rst_eol", 32'(pix_eol), 32'd0);
    chk("rst_afull", 32'(almost_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rgb", {8'd0, pix_r, pix_g, pix_b}, 32'd0);
    #10;
    rst = 1'b0;

    // Single quad, sink always ready
    R_quad = 32'h11223344; G_quad = 32'hAABBCCDD; B_quad = 32'h01020304;
    valid_in = 1'b1; pix_ready = 1'b1;
    step();
    valid_in = 1'b0;
    chk("q1_valid", 32'(pix_valid), 32'd1);
    chk("q1_rgb0", {8'd0, pix_r, pix_g, pix_b}, 32'h00_11_AA_01);
    chk("q1_sof0", 32'(pix_sof), 32'd1);
    chk("q1_count", 32'(fifo_count), 32'd1);
    step();
    chk("q1_r1", 32'(pix_r), 32'h22);
    chk("q1_sof1", 32'(pix_sof), 32'd0);
    step();
    chk("q1_r2", 32'(pix_r), 32'h33);
    step();
    chk("q1_rgb3", {8'd0, pix_r, pix_g, pix_b}, 32'h00_44_DD_04);
    chk("q1_eol3", 32'(pix_eol), 32'd0);
    step();
    chk("q1_empty", 32'(pix_valid), 32'd0);
    chk("q1_empty_r", 32'(pix_r), 32'd0);
    chk("q1_empty_cnt", 32'(fifo_count), 32'd0);

    // Ready pattern 1,0,0,1 mid-quad; quad lands at x=4..7 so lane 3 is EOL
    R_quad = 32'hA0A1A2A3; G_quad = '0; B_quad = '0;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("hold_r0", 32'(pix_r), 32'hA0);
    step();
    chk("hold_r1", 32'(pix_r), 32'hA1);
    pix_ready = 1'b0;
    step();
    chk("hold_r1a", 32'(pix_r), 32'hA1);
    step();
    chk("hold_r1b", 32'(pix_r), 32'hA1);
    chk("hold_eol", 32'(pix_eol), 32'd0);
    pix_ready = 1'b1;
    step();
    chk("hold_r2", 32'(pix_r), 32'hA2);
    step();
    chk("hold_r3", 32'(pix_r), 32'hA3);
    chk("hold_eol3", 32'(pix_eol), 32'd1);
    step();
    chk("hold_empty", 32'(pix_valid), 32'd0);

    // Second line: two quads back to back, push and transfer together
    seq = 64'hB0B1B2B3C0C1C2C3;
    R_quad = 32'hB0B1B2B3;
    valid_in = 1'b1;
    step();
    chk("l2_r0", 32'(pix_r), 32'hB0);
    chk("l2_cnt0", 32'(fifo_count), 32'd1);
    R_quad = 32'hC0C1C2C3;
    step();
    valid_in = 1'b0;
    chk("l2_r1", 32'(pix_r), 32'hB1);
    chk("l2_cnt1", 32'(fifo_count), 32'd2);
    for (int k = 2; k < 8; k++) begin
      step();
      chk("l2_r", 32'(pix_r), 32'(seq[63 - 8*k -: 8]));
      chk("l2_eol", 32'(pix_eol), 32'(k == 7));
      chk("l2_sof", 32'(pix_sof), 32'd0);
    end
    step();
    chk("l2_empty", 32'(pix_valid), 32'd0);

    // Overflow: five pushes into a 4-deep FIFO with the sink stalled
    pix_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_quad(i);
      valid_in = 1'b1;
      step();
      chk("of_cnt", 32'(fifo_count), (i < 4) ? 32'(i + 1) : 32'd4);
      chk("of_afull", 32'(almost_full), 32'(i >= 2));
      chk("of_ovf", 32'(overflow), 32'(i == 4));
    end
    valid_in = 1'b0;
    chk("of_sof", 32'(pix_sof), 32'd1);
    chk("of_r0", 32'(pix_r), 32'(lb(qr(0), 0)));
    pix_ready = 1'b1;
    for (int l = 1; l < 4; l++) begin
      step();
      chk("of_lane_r", 32'(pix_r), 32'(lb(qr(0), l)));
      chk("of_lane_cnt", 32'(fifo_count), 32'd4);
    end
    // Push while full on the popping edge must still be dropped
    set_quad(5);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("fullpop_cnt", 32'(fifo_count), 32'd3);
    chk("fullpop_ovf", 32'(overflow), 32'd1);
    for (int q = 1; q < 4; q++) begin
      for (int l = 0; l < 4; l++) begin
        chk("drain_rgb", {8'd0, pix_r, pix_g, pix_b},
            {8'd0, lb(qr(q), l), lb(qg(q), l), lb(qb(q), l)});
        chk("drain_eol", 32'(pix_eol), 32'(q != 2 && l == 3));
        step();
      end
    end
    chk("drain_empty", 32'(pix_valid), 32'd0);
    chk("drain_ovf_sticky", 32'(overflow), 32'd1);

    // sync_clear clears the sticky overflow
    sync_clear = 1'b1;
    step();
    sync_clear = 1'b0;
    chk("clr_ovf", 32'(overflow), 32'd0);
    chk("clr_cnt", 32'(fifo_count), 32'd0);

    // sync_clear with 3 buffered, a push and a transfer on the same edge
    pix_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_quad(i);
      valid_in = 1'b1;
      step();
    end
    valid_in = 1'b0;
    chk("sc_cnt3", 32'(fifo_count), 32'd3);
    chk("sc_afull", 32'(almost_full), 32'd1);
    pix_ready = 1'b1;
    step();
    chk("sc_r1", 32'(pix_r), 32'(lb(qr(0), 1)));
    set_quad(3);
    sync_clear = 1'b1; valid_in = 1'b1;
    step();
    sync_clear = 1'b0;
    chk("sc_cnt0", 32'(fifo_count), 32'd0);
    chk("sc_valid", 32'(pix_valid), 32'd0);
    chk("sc_ovf", 32'(overflow), 32'd0);
    chk("sc_afull0", 32'(almost_full), 32'd0);
    set_quad(4);
    pix_ready = 1'b0;
    step();
    valid_in = 1'b0;
    chk("sc_next_sof", 32'(pix_sof), 32'd1);
    chk("sc_next_r", 32'(pix_r), 32'(lb(qr(4), 0)));
    chk("sc_next_cnt", 32'(fifo_count), 32'd1);

    // Asynchronous reset mid-quad with two quads buffered
    set_quad(2);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("ar_cnt2", 32'(fifo_count), 32'd2);
    pix_ready = 1'b1;
    step();
    chk("ar_r1", 32'(pix_r), 32'(lb(qr(4), 1)));
    #3;
    rst = 1'b1;
    #1;
    chk("ar_valid", 32'(pix_valid), 32'd0);
    chk("ar_cnt", 32'(fifo_count), 32'd0);
    chk("ar_flags", {28'd0, pix_sof, pix_eol, almost_full, overflow}, 32'd0);
    chk("ar_rgb", {8'd0, pix_r, pix_g, pix_b}, 32'd0);
    step();
    rst = 1'b0;
    set_quad(3);
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    chk("ar_next_sof", 32'(pix_sof), 32'd1);
    chk("ar_next_r", 32'(pix_r), 32'(lb(qr(3), 0)));
    chk("ar_next_cnt", 32'(fifo_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/quad_serializer.md
QUAD_SERIALIZER -- requirements
Module: quad_serializer

Interface
REQ-001 Parameter DEPTH, default 4, number of quad entries in the input FIFO (power of two, >= 2).
REQ-002 Parameter H_ACTIVE, default 640, active pixels per line (multiple of 4).
REQ-003 Parameter V_ACTIVE, default 480, active lines per frame.
REQ-004 clk  input  1  single clock; all state SHALL be updated on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 R_quad  input  32  red bytes of 4 pixels; [31:24]=lane 0 (leftmost) ... [7:0]=lane 3.
REQ-007 G_quad  input  32  green bytes, same lane packing.
REQ-008 B_quad  input  32  blue bytes, same lane packing.
REQ-009 valid_in  input  1  quad write strobe from the shader stage, no backpressure.
REQ-010 sync_clear  input  1  synchronous flush and frame realign.
REQ-011 pix_ready  input  1  scanout sink accepts a pixel this cycle.
REQ-012 pix_r, pix_g, pix_b  output  8 each  current pixel colour.
REQ-013 pix_valid  output  1  a pixel is presented.
REQ-014 pix_sof  output  1  presented pixel is x=0, y=0.
REQ-015 pix_eol  output  1  presented pixel is x=H_ACTIVE-1.
REQ-016 almost_full  output  1  throttle request to the upstream dispatcher.
REQ-017 overflow  output  1  sticky: a quad was dropped.
REQ-018 fifo_count  output  $clog2(DEPTH)+1  occupied quad entries.

Function
REQ-019 Push: valid_in=1 and fifo_count<DEPTH at the edge SHALL store {R,G,B}_quad at the tail.
REQ-020 Full: valid_in=1 with fifo_count==DEPTH SHALL drop the quad and set overflow, even if a pop occurs that same cycle (fullness judged on pre-edge count).
REQ-021 pix_valid SHALL equal (fifo_count!=0); pix_r/g/b SHALL be the head-quad byte selected by a 2-bit lane counter, driven from registered state only.
REQ-022 Latency: a quad pushed at edge N SHALL present lane 0 in the cycle after edge N when the FIFO was empty.
REQ-023 Transfer = pix_valid & pix_ready; each transfer SHALL advance lane by 1; transfer at lane 3 SHALL pop the head and return lane to 0.
REQ-024 With pix_valid=1 and pix_ready=0, pix_r/g/b/sof/eol SHALL hold stable.
REQ-025 Simultaneous push and pop (not full) SHALL leave fifo_count unchanged; push into empty FIFO with pix_ready=1 SHALL not transfer until the following cycle.
REQ-026 x counter (0..H_ACTIVE-1) SHALL increment per transfer and wrap to 0 after H_ACTIVE-1, incrementing y; y SHALL wrap to 0 after V_ACTIVE-1.
REQ-027 pix_sof = pix_valid & x==0 & y==0; pix_eol = pix_valid & x==H_ACTIVE-1.
REQ-028 almost_full SHALL be 1 when fifo_count >= DEPTH-1 (covers the shader's one-cycle latency).
REQ-029 FIFO read/write pointers SHALL wrap modulo DEPTH.
REQ-030 sync_clear=1 SHALL empty the FIFO, zero lane, x, y; clear wins over a simultaneous push (quad discarded, overflow unchanged) and over a transfer.
REQ-031 overflow SHALL clear only on rst or sync_clear.

Reset
REQ-032 rst=1 SHALL immediately force fifo_count=0, pointers=0, lane=0, x=0, y=0, overflow=0, hence pix_valid=0, pix_sof=0, pix_eol=0, almost_full=0, pix_r/g/b=0.
REQ-033 Reset asserted mid-quad SHALL discard all buffered pixels; first quad after release SHALL present as x=0,y=0 with pix_sof=1.
REQ-034 Storage array contents need not be reset; outputs SHALL read 0 while empty.

Verification
REQ-035 Single quad R=0x11223344, pix_ready=1 -> pix_r 0x11,0x22,0x33,0x44 on consecutive cycles, first with pix_sof=1, then pix_valid=0.
REQ-036 Push DEPTH+1 quads back-to-back, pix_ready=0 -> almost_full=1 after DEPTH-1 pushes, fifo_count=DEPTH, overflow=1, last quad never output.
REQ-037 Stream H_ACTIVE*V_ACTIVE pixels with random pix_ready -> pix_eol every 640th transfer, pix_sof on transfer 0 and 307200, data in order, no loss.
REQ-038 pix_ready toggled 1,0,0,1 mid-quad -> lane/data held during 0 cycles, no duplicated or skipped bytes.
REQ-039 sync_clear with FIFO at 3 and valid_in=1 same cycle -> fifo_count=0, overflow unchanged, next quad presents with pix_sof=1.
REQ-040 rst asserted asynchronously between edges with 2 quads buffered -> pix_valid=0 before next edge, all counters 0.
